// File: rtl/operand_fetch_if.sv
// Handshake bundles around operand_fetch: decode-to-fetch request and fetch-to-execute result.
interface of_req_if #(
  parameter int REG_ID_W = 4,
  parameter int OPC_W    = 8
);
  logic                req_valid;
  logic                req_ready;
  logic [OPC_W-1:0]    req_opcode;
  logic                req_src0_en;
  logic                req_src1_en;
  logic                req_dst_en;
  logic [REG_ID_W-1:0] req_src0;
  logic [REG_ID_W-1:0] req_src1;
  logic [REG_ID_W-1:0] req_dst;

  modport master (
    output req_valid, req_opcode, req_src0_en, req_src1_en, req_dst_en,
           req_src0, req_src1, req_dst,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_opcode, req_src0_en, req_src1_en, req_dst_en,
           req_src0, req_src1, req_dst,
    output req_ready
  );
endinterface

interface of_exe_if #(
  parameter int REG_ID_W = 4,
  parameter int OPC_W    = 8,
  parameter int VEC_W    = 256
);
  logic                out_valid;
  logic                out_ready;
  logic [OPC_W-1:0]    out_opcode;
  logic [VEC_W-1:0]    out_a;
  logic [VEC_W-1:0]    out_b;
  logic                out_dst_en;
  logic [REG_ID_W-1:0] out_dst;

  modport master (
    output out_valid, out_opcode, out_a, out_b, out_dst_en, out_dst,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_opcode, out_a, out_b, out_dst_en, out_dst,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: holds one decoded instruction until its registers are valid in the
// scoreboard, reads the sources, invalidates the destination and hands off to execute.
module operand_fetch #(
  parameter int NUM_REGS = 16,
  parameter int REG_ID_W = $clog2(NUM_REGS),
  parameter int VEC_W    = 256,
  parameter int OPC_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  of_req_if.slave             req,
  of_exe_if.master            exe,
  input  logic [NUM_REGS-1:0] rf_valid_mask,
  output logic [REG_ID_W-1:0] rf_rd0_id,
  output logic [REG_ID_W-1:0] rf_rd1_id,
  input  logic [VEC_W-1:0]    rf_rd0_data,
  input  logic [VEC_W-1:0]    rf_rd1_data,
  output logic                rf_inv_en,
  output logic [REG_ID_W-1:0] rf_inv_id,
  input  logic                halted,
  output logic [15:0]         stall_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic                src0_en_q, src0_en_d;
  logic                src1_en_q, src1_en_d;
  logic                dst_en_q, dst_en_d;
  logic [REG_ID_W-1:0] src0_q, src0_d;
  logic [REG_ID_W-1:0] src1_q, src1_d;
  logic [REG_ID_W-1:0] dst_q, dst_d;
  logic [OPC_W-1:0]    out_opc_q, out_opc_d;
  logic [VEC_W-1:0]    out_a_q, out_a_d;
  logic [VEC_W-1:0]    out_b_q, out_b_d;
  logic                out_dst_en_q, out_dst_en_d;
  logic [REG_ID_W-1:0] out_dst_q, out_dst_d;
  logic [15:0]         stall_q, stall_d;

  logic accept;
  logic operands_ready;
  logic release_now;

  // Reset also masks the accept so decode never sees a handshake that gets dropped.
  assign req.req_ready = !reset && !halted &&
                         (state_q == IDLE || (state_q == ISSUE && exe.out_ready));
  assign accept        = req.req_valid && req.req_ready;

  // Disabled operands never block; a repeated id just tests the same mask bit twice.
  assign operands_ready = (!src0_en_q || rf_valid_mask[src0_q]) &&
                          (!src1_en_q || rf_valid_mask[src1_q]) &&
                          (!dst_en_q  || rf_valid_mask[dst_q]);
  assign release_now    = (state_q == WAIT) && operands_ready;

  assign rf_rd0_id = (state_q == WAIT) ? src0_q : '0;
  assign rf_rd1_id = (state_q == WAIT) ? src1_q : '0;
  assign rf_inv_en = !reset && release_now && dst_en_q;
  assign rf_inv_id = rf_inv_en ? dst_q : '0;

  assign exe.out_valid  = (state_q == ISSUE);
  assign exe.out_opcode = out_opc_q;
  assign exe.out_a      = out_a_q;
  assign exe.out_b      = out_b_q;
  assign exe.out_dst_en = out_dst_en_q;
  assign exe.out_dst    = out_dst_q;
  assign stall_cycles   = stall_q;

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    src0_en_d    = src0_en_q;
    src1_en_d    = src1_en_q;
    dst_en_d     = dst_en_q;
    src0_d       = src0_q;
    src1_d       = src1_q;
    dst_d        = dst_q;
    out_opc_d    = out_opc_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_dst_en_d = out_dst_en_q;
    out_dst_d    = out_dst_q;
    stall_d      = stall_q;

    case (state_q)
      IDLE: ;
      WAIT: begin
        if (operands_ready) begin
          out_opc_d    = opc_q;
          out_a_d      = src0_en_q ? rf_rd0_data : '0;
          out_b_d      = src1_en_q ? rf_rd1_data : '0;
          out_dst_en_d = dst_en_q;
          out_dst_d    = dst_q;
          state_d      = ISSUE;
        end else begin
          stall_d = sat_inc16(stall_q);
        end
      end
      ISSUE: begin
        if (exe.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new instruction can only land in IDLE or on the ISSUE handshake cycle.
    if (accept) begin
      opc_d     = req.req_opcode;
      src0_en_d = req.req_src0_en;
      src1_en_d = req.req_src1_en;
      dst_en_d  = req.req_dst_en;
      src0_d    = req.req_src0;
      src1_d    = req.req_src1;
      dst_d     = req.req_dst;
      state_d   = WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      opc_q        <= '0;
      src0_en_q    <= 1'b0;
      src1_en_q    <= 1'b0;
      dst_en_q     <= 1'b0;
      src0_q       <= '0;
      src1_q       <= '0;
      dst_q        <= '0;
      out_opc_q    <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_dst_en_q <= 1'b0;
      out_dst_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      src0_en_q    <= src0_en_d;
      src1_en_q    <= src1_en_d;
      dst_en_q     <= dst_en_d;
      src0_q       <= src0_d;
      src1_q       <= src1_d;
      dst_q        <= dst_d;
      out_opc_q    <= out_opc_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_dst_en_q <= out_dst_en_d;
      out_dst_q    <= out_dst_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

- Reader/consumer side of the vector register file and its valid-counter scoreboard.
- Accepts one decoded instruction at a time and waits until its source and destination registers are valid in the scoreboard.
- Reads the source vectors, pulses mark-invalid on the destination, then presents the operands to the execute stage over a valid/ready handshake.
- Sits between decode and execute; owns no register storage.

## Interface
Parameters:
- NUM_REGS, 16: register count; equals MAX_REG_ID.
- REG_ID_W, 4: register id width, $clog2(NUM_REGS).
- VEC_W, 256: VectorValue width in bits.
- OPC_W, 8: opaque opcode payload width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  decode presents an instruction.
- req_ready  out  1  fetch accepts the instruction this cycle.
- req_opcode  in  OPC_W  payload, passed through unchanged.
- req_src0_en, req_src1_en, req_dst_en  in  1 each  operand used.
- req_src0, req_src1, req_dst  in  REG_ID_W each  register ids.
- rf_valid_mask  in  NUM_REGS  bit i = is_valid(i), i.e. written == invalidated.
- rf_rd0_id, rf_rd1_id  out  REG_ID_W  combinational read addresses.
- rf_rd0_data, rf_rd1_data  in  VEC_W  same-cycle register read data.
- rf_inv_en  out  1  one-cycle mark_invalid pulse.
- rf_inv_id  out  REG_ID_W  id for mark_invalid.
- halted  in  1  machine HALT flag.
- out_valid  out  1  operands ready for execute.
- out_ready  in  1  execute accepts.
- out_opcode  out  OPC_W
- out_a, out_b  out  VEC_W  captured operand values.
- out_dst_en  out  1
- out_dst  out  REG_ID_W
- stall_cycles  out  16  saturating count of WAIT cycles spent blocked.

## Operation
- FSM states: IDLE, WAIT, ISSUE. Reset state: IDLE.
- Reset values: all outputs 0; stall_cycles = 0.
- Accept: req_ready = !halted && (state==IDLE || (state==ISSUE && out_ready)).
  - On req_valid && req_ready, latch opcode, the three enables and the three ids, then go to WAIT.
- WAIT:
  - rf_rd0_id = latched src0; rf_rd1_id = latched src1. In other states both drive 0.
  - Ready condition: every enabled operand (src0, src1, dst) has its rf_valid_mask bit set. Disabled operands are ignored.
  - Checking dst avoids WAW hazards and bounds each register's outstanding invalidations from this block to 1, so the 8-bit scoreboard counters cannot wrap.
  - When ready, in the same cycle:
    - capture out_a = src0_en ? rf_rd0_data : 0, and out_b likewise from src1;
    - if dst_en, assert rf_inv_en=1 with rf_inv_id=dst;
    - go to ISSUE.
  - When not ready: stay in WAIT and increment stall_cycles, saturating at 0xFFFF.
- ISSUE: out_valid=1, with all out_* fields held stable until out_ready.
  - out_ready && new request accepted: go to WAIT.
  - out_ready, no new request: go to IDLE.
  - !out_ready: stay in ISSUE.
- Repeated ids are legal. src0==src1 or src==dst needs only that register's valid bit.
- halted: only gates new accepts. An instruction already in WAIT or ISSUE completes normally.
- rf_inv_en is asserted only on the WAIT→ISSUE transition, never elsewhere.

## Timing
- Minimum latency: accept at edge N, WAIT during cycle N+1, out_valid from cycle N+2.
- Throughput: one instruction per 2 cycles at best, since accept overlaps the ISSUE handshake.
- Scoreboard ordering:
  - A rf_inv_en pulse in cycle T is applied at edge T; the register file clears the mask bit from T+1.
  - The next instruction reaches WAIT no earlier than T+2, so no bypass is needed.
- Mask sampling: rf_valid_mask is sampled only in WAIT. A bit rising in cycle T allows the WAIT→ISSUE transition at edge T.
- Read data: rf_rd*_data must be valid in the same cycle as rf_rd*_id.
- Reset mid-operation: return to IDLE and zero all outputs. No rf_inv_en is emitted in the reset cycle or afterwards for the dropped instruction.

## Test plan
- Basic issue:
  - Stimulus: all mask bits 1; issue src0=2, src1=3, dst=5 with reg2=0xAA.., reg3=0x55..
  - Required: out_valid 2 cycles after accept; out_a=0xAA..; out_b=0x55..; one rf_inv_en pulse with id 5; stall_cycles=0.
- RAW stall:
  - Stimulus: mask bit 3 low for 7 cycles, then high; instruction reads src1=3.
  - Required: stay in WAIT for 7 cycles, stall_cycles=7, out_b = reg3 value sampled in the release cycle.
- Back-to-back dependency:
  - Stimulus: instruction A writes r4; instruction B reads r4. A register-file model applies mark_invalid, and the bench re-validates r4 4 cycles later.
  - Required: B waits until re-validation and never issues with stale data.
- Backpressure plus overlap:
  - Stimulus: hold out_ready=0 for 5 cycles; then raise out_ready with req_valid=1.
  - Required: outputs stable for all 5 cycles; req_ready=1 only in the handshake cycle; FSM goes directly to WAIT.
- Halt and disabled operands:
  - Stimulus: halted=1 while an instruction is in WAIT; the instruction has all enables 0 and every mask bit is 0.
  - Required: the instruction still issues with out_a=out_b=0 and no rf_inv_en; req_ready stays 0 afterwards.
- Reset in WAIT:
  - Stimulus: assert reset 1 cycle while blocked.
  - Required: next cycle state IDLE, every output 0 including stall_cycles, rf_inv_en never pulses.
